itype_exec_unit: RTL and testbench
==================================

ITYPE_EXEC_UNIT -- requirements
Module: itype_exec_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter SHW, default $clog2(XLEN), shift-amount and shift-counter width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  instruction and operand present.
REQ-006 in_ready  output  1  unit can accept; high only in state IDLE.
REQ-007 instr  input  32  complete RV instruction word.
REQ-008 rs1  input  XLEN  first source register value.
REQ-009 out_valid  output  1  result and illegal are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  XLEN  registered operation result.
REQ-012 illegal  output  1  registered flag: instruction not a supported OP-IMM encoding.

Function
REQ-013 Transfer in occurs when in_valid and in_ready are high on a clock edge; instr and rs1 are captured then and the inputs are ignored afterwards.
REQ-014 Decode: opcode instr[6:0], funct3 instr[14:12], imm instr[31:20] sign-extended to XLEN, shamt instr[20+SHW-1:20].
REQ-015 Supported ops at opcode 7'b0010011: ADDI 000, SLTI 010, SLTIU 011, XORI 100, ORI 110, ANDI 111, SLLI 001, SRLI/SRAI 101.
REQ-016 ADDI wraps modulo 2^XLEN; SLTI is a signed compare; SLTIU is an unsigned compare against the sign-extended imm; both SLT ops yield 1 or 0, zero-extended.
REQ-017 Shift qualifier: for XLEN=32, instr[31:25] must be 0000000, or 0100000 for SRAI only; for XLEN=64, instr[31:26] must be 000000, or 010000 for SRAI only.
REQ-018 Any other opcode, funct3 or shift qualifier gives result 0 and illegal=1; otherwise illegal=0.
REQ-019 FSM states: IDLE, SHIFT, DONE.
REQ-020 IDLE to DONE on accept for non-shift, illegal, or shamt=0 instructions; result is registered, giving out_valid one cycle after accept.
REQ-021 IDLE to SHIFT on accept for a legal shift with shamt>0: load the working register with rs1 and the counter with shamt.
REQ-022 SHIFT: each cycle, shift the working register one bit (SLLI zero-fill, SRLI zero-fill, SRAI sign-fill) and decrement the counter; on the cycle the counter reaches 0, move to DONE; latency from accept to out_valid is shamt+1 cycles.
REQ-023 DONE: out_valid=1; result and illegal are held stable until out_ready; on out_ready go to IDLE, with out_valid low the next cycle.
REQ-024 No accept in the DONE-to-IDLE cycle; minimum initiation interval is 2 cycles.
REQ-025 in_valid in SHIFT or DONE has no effect; out_ready outside DONE has no effect.

Reset
REQ-026 While rst is high: state IDLE, out_valid 0, result 0, illegal 0, counter 0, working register 0; in_ready is high after release.
REQ-027 Reset asserted in SHIFT or DONE aborts the operation; the pending result is discarded and never presented.

Structure
REQ-028 Shared package itype_pkg holds OP_IMM opcode constant, funct3 encodings, SRAI qualifier constants and the state enum.
REQ-029 One sub-module, itype_serial_shifter, holds the working register, counter and shift-direction/fill control; the decode and one-cycle ops stay in itype_exec_unit.

Verification
REQ-030 ADDI x, rs1=32'h0000_0005, imm=12'hFFF -> result 32'h0000_0004, illegal 0, out_valid 1 cycle after accept.
REQ-031 SLTIU rs1=32'h0000_0001, imm=12'hFFF -> result 1; SLTI same operands -> result 0.
REQ-032 SRAI rs1=32'h8000_0000, shamt 31 -> out_valid 32 cycles after accept, result 32'hFFFF_FFFF; SLLI with shamt 0 -> latency 1, result equals rs1.
REQ-033 opcode 7'b0110011, or SRLI with instr[31:25]=0000001 -> result 0, illegal 1, latency 1.
REQ-034 Hold out_ready low 5 cycles in DONE -> result stable and in_ready low throughout; rst asserted mid-SHIFT -> out_valid never asserts and in_ready is high after release.

Source files
------------

// File: rtl/itype_pkg.sv
// Shared definitions for the OP-IMM execution unit: opcode, funct3
// encodings, SRAI shift qualifiers and the control FSM state encoding.
package itype_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_SLLI  = 3'b001;
  localparam logic [2:0] F3_SLTI  = 3'b010;
  localparam logic [2:0] F3_SLTIU = 3'b011;
  localparam logic [2:0] F3_XORI  = 3'b100;
  localparam logic [2:0] F3_SRXI  = 3'b101;
  localparam logic [2:0] F3_ORI   = 3'b110;
  localparam logic [2:0] F3_ANDI  = 3'b111;

  // Upper instruction bits that select SRAI over SRLI (RV32 / RV64 layouts)
  localparam logic [6:0] QUAL32_SRAI = 7'b0100000;
  localparam logic [5:0] QUAL64_SRAI = 6'b010000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/itype_serial_shifter.sv
// One-bit-per-cycle shifter for SLLI/SRLI/SRAI.
// Ports:
//   clk, rst     clock and async active-high reset
//   load         capture din/shamt/left/arith as a new operation
//   step         advance one bit while the counter is non-zero
//   din, shamt   operand and shift amount captured on load
//   left, arith  direction (1 = left) and sign fill for right shifts
//   next_c       working register after the next one-bit shift
//   last_c       counter is 1: the next step completes the operation
module itype_serial_shifter
  import itype_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] din,
  input  logic [SHW-1:0]  shamt,
  input  logic            left,
  input  logic            arith,
  output logic [XLEN-1:0] next_c,
  output logic            last_c
);

  logic [XLEN-1:0] work;
  logic [SHW-1:0]  cnt;
  logic            left_q;
  logic            arith_q;

  // Right shifts fill with the sign bit only for SRAI
  always_comb begin
    next_c = {arith_q & work[XLEN-1], work[XLEN-1:1]};
    if (left_q) begin
      next_c = {work[XLEN-2:0], 1'b0};
    end
  end

  assign last_c = (cnt == SHW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work    <= '0;
      cnt     <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      work    <= din;
      cnt     <= shamt;
      left_q  <= left;
      arith_q <= arith;
    end else if (step && (cnt != '0)) begin
      work <= next_c;
      cnt  <= cnt - SHW'(1);
    end
  end

endmodule

// File: rtl/itype_exec_unit.sv
// RISC-V OP-IMM execution unit: single-cycle ALU ops, serial shifts.
// Ports:
//   clk, rst             clock and async active-high reset
//   in_valid, in_ready   operand handshake (ready only when idle)
//   instr, rs1           instruction word and first source operand
//   out_valid, out_ready result handshake
//   result, illegal      registered result and unsupported-encoding flag
module itype_exec_unit
  import itype_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  state_t state;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm;
  logic [SHW-1:0]  shamt;
  logic            qual_zero;
  logic            qual_srai;
  logic            unused_fields;

  logic [XLEN-1:0] alu_c;
  logic            illegal_c;
  logic            start_shift_c;
  logic            left_c;
  logic            arith_c;
  logic [XLEN-1:0] shift_next_c;
  logic            shift_last_c;
  logic            accept_c;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign imm    = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign shamt  = instr[20 +: SHW];

  // RV64 uses a 6-bit shamt, so its qualifier field is one bit narrower
  assign qual_zero = (XLEN == 64) ? (instr[31:26] == 6'b000000)  : (instr[31:25] == 7'b0000000);
  assign qual_srai = (XLEN == 64) ? (instr[31:26] == QUAL64_SRAI) : (instr[31:25] == QUAL32_SRAI);

  // Register-number fields play no part in execution
  assign unused_fields = ^{instr[19:15], instr[11:7]};

  // Decode and one-cycle operations; shifts with shamt=0 pass rs1 through
  always_comb begin
    alu_c         = '0;
    illegal_c     = 1'b0;
    start_shift_c = 1'b0;
    left_c        = 1'b0;
    arith_c       = 1'b0;
    if (opcode != OP_IMM) begin
      illegal_c = 1'b1;
    end else begin
      case (funct3)
        F3_ADDI:  alu_c = rs1 + imm;
        F3_SLTI:  alu_c = XLEN'($signed(rs1) < $signed(imm));
        F3_SLTIU: alu_c = XLEN'(rs1 < imm);
        F3_XORI:  alu_c = rs1 ^ imm;
        F3_ORI:   alu_c = rs1 | imm;
        F3_ANDI:  alu_c = rs1 & imm;
        F3_SLLI: begin
          if (qual_zero) begin
            alu_c         = rs1;
            start_shift_c = (shamt != '0);
            left_c        = 1'b1;
          end else begin
            illegal_c = 1'b1;
          end
        end
        F3_SRXI: begin
          if (qual_zero || qual_srai) begin
            alu_c         = rs1;
            start_shift_c = (shamt != '0);
            arith_c       = qual_srai;
          end else begin
            illegal_c = 1'b1;
          end
        end
        default: illegal_c = 1'b1;
      endcase
    end
  end

  assign accept_c = (state == IDLE) && in_valid;

  itype_serial_shifter #(
    .XLEN (XLEN),
    .SHW  (SHW)
  ) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .load   (accept_c && start_shift_c),
    .step   (state == SHIFT),
    .din    (rs1),
    .shamt  (shamt),
    .left   (left_c),
    .arith  (arith_c),
    .next_c (shift_next_c),
    .last_c (shift_last_c)
  );

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (start_shift_c) begin
              state <= SHIFT;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= alu_c;
              illegal   <= illegal_c;
            end
          end
        end
        SHIFT: begin
          if (shift_last_c) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= shift_next_c;
            illegal   <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_itype_exec_unit.sv
// Directed self-checking bench for itype_exec_unit (XLEN=32).
module tb_itype_exec_unit;

  localparam logic [6:0] OPI = 7'b0010011;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        illegal;

  int n_pass;
  int n_total;
  int lat;

  itype_exec_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs1       (rs1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ienc(input logic [11:0] imm, input logic [2:0] f3,
                                       input logic [6:0] op);
    return {imm, 5'd1, f3, 5'd2, op};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present one instruction, then count cycles from the accept edge to out_valid
  task automatic issue(input logic [31:0] ins, input logic [31:0] a);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) check("in_ready_timeout", 64'(in_ready), 64'd1);
    instr = ins; rs1 = a; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; instr = '0; rs1 = '0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ov_low"}, 64'(out_valid), 64'd0);
    check({tag, "_rdy_high"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] exp_res, input logic exp_ill, input int exp_lat);
    issue(ins, a);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, 64'(result), 64'(exp_res));
    check({tag, "_ill"}, 64'(illegal), 64'(exp_ill));
    consume(tag);
  endtask

  initial begin
    logic [31:0] held;
    logic        bad;
    logic        seen;
    n_pass = 0; n_total = 0; lat = 0;
    clk = 1'b0; rst = 1'b1;
    in_valid = 1'b0; instr = '0; rs1 = '0; out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    run_op("addi", ienc(12'hFFF, 3'b000, OPI), 32'h0000_0005, 32'h0000_0004, 1'b0, 1);
    run_op("sltiu", ienc(12'hFFF, 3'b011, OPI), 32'h0000_0001, 32'h0000_0001, 1'b0, 1);
    run_op("slti", ienc(12'hFFF, 3'b010, OPI), 32'h0000_0001, 32'h0000_0000, 1'b0, 1);
    run_op("xori", ienc(12'h0FF, 3'b100, OPI), 32'hF0F0_1234, 32'hF0F0_12CB, 1'b0, 1);
    run_op("ori", ienc(12'h00A, 3'b110, OPI), 32'h0000_0005, 32'h0000_000F, 1'b0, 1);
    run_op("andi", ienc(12'h0F0, 3'b111, OPI), 32'hDEAD_BEEF, 32'h0000_00E0, 1'b0, 1);
    run_op("srai31", ienc({7'b0100000, 5'd31}, 3'b101, OPI), 32'h8000_0000,
           32'hFFFF_FFFF, 1'b0, 32);
    run_op("slli0", ienc({7'b0000000, 5'd0}, 3'b001, OPI), 32'h1234_5678,
           32'h1234_5678, 1'b0, 1);
    run_op("slli4", ienc({7'b0000000, 5'd4}, 3'b001, OPI), 32'h8000_0001,
           32'h0000_0010, 1'b0, 5);
    run_op("srli8", ienc({7'b0000000, 5'd8}, 3'b101, OPI), 32'h8000_FF00,
           32'h0080_00FF, 1'b0, 9);
    run_op("op_reg", ienc(12'h001, 3'b000, 7'b0110011), 32'h0000_0005,
           32'h0000_0000, 1'b1, 1);
    run_op("srli_badq", ienc({7'b0000001, 5'd3}, 3'b101, OPI), 32'hFFFF_0000,
           32'h0000_0000, 1'b1, 1);

    // Result held while the consumer stalls; new requests are ignored
    issue(ienc(12'h7FF, 3'b000, OPI), 32'h7FFF_FFFF);
    check("stall_lat", 64'(lat), 64'd1);
    held = result;
    check("stall_res", 64'(held), 64'h8000_07FE);
    bad = 1'b0;
    in_valid = 1'b1; instr = ienc(12'h001, 3'b000, OPI); rs1 = 32'h1;
    repeat (5) begin
      @(posedge clk); #1;
      if (result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
    end
    in_valid = 1'b0;
    check("stall_stable", 64'(bad), 64'd0);
    consume("stall");

    // Reset during SHIFT discards the pending result
    issue_no_wait_srai();
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_ov", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_never_valid", 64'(seen), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);

    run_op("post_abort", ienc(12'h003, 3'b000, OPI), 32'h0000_0010, 32'h0000_0013, 1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  task automatic issue_no_wait_srai();
    instr = ienc({7'b0100000, 5'd31}, 3'b101, OPI);
    rs1 = 32'h8000_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; instr = '0; rs1 = '0;
    check("abort_accepted", 64'(in_ready), 64'd0);
  endtask

endmodule
